wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file of the SIMD AES pipeline; the consumer end of the MEM/WB pipeline register. Takes the registered WB bundle (memory data, ALU result, destination, MemToReg, RegWrite), selects the write-back value, commits it to a 32 x 64-bit register file on the clock edge, and serves two combinational read ports to decode. Also exposes the selected write-back value for forwarding and a commit counter for debug and performance monitoring.

## Interface
- DATA_W, 64, register and data-path width
- REG_COUNT, 32, number of architectural registers; register 0 is hardwired zero
- ADDR_W, 5, register index width, equal to clog2(REG_COUNT)
- CNT_W, 32, width of the commit counter
- Clocking and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- WB_MemData  in  DATA_W  load data from the MEM/WB register
- WB_ALUResult  in  DATA_W  ALU result from the MEM/WB register
- WB_rd  in  ADDR_W  destination register index
- WB_MemToReg  in  1  1 selects WB_MemData, 0 selects WB_ALUResult
- WB_RegWrite  in  1  commit enable
- rs1, rs2  in  ADDR_W  read addresses from decode
- rd1, rd2  out  DATA_W  read data
- wb_data  out  DATA_W  selected write-back value, combinational, for forwarding
- wb_commit  out  1  combinational: WB_RegWrite && WB_rd != 0
- retire_count  out  CNT_W  number of committed register writes since reset

## Operation
- wb_data = WB_MemToReg ? WB_MemData : WB_ALUResult. The value is valid regardless of WB_RegWrite.
- Commit: on a rising `clk` edge with `rst_n` high and wb_commit = 1, regs[WB_rd] <= wb_data. Writes to index 0 are discarded.
- Reads are combinational. rs = 0 always returns 0. Otherwise the port returns regs[rs], subject to the bypass rule in Configuration.
- retire_count increments by 1 on every edge where wb_commit = 1. It wraps modulo 2^CNT_W with no saturation.
- Writes with WB_RegWrite = 0 change nothing, independent of WB_rd and WB_MemToReg.
- Both read ports may address the same register, or the write target, at once. Each port resolves independently.

## Timing
- Reset, asynchronous assertion: all regs[1..REG_COUNT-1] = 0 and retire_count = 0 immediately. rd1 and rd2 then read 0 for every address.
- wb_data and wb_commit are combinational from their inputs, including during reset.
- While rst_n is low, no write and no count occurs.
- A commit pending on the edge where rst_n deasserts is not performed. The first commit happens on the first edge with rst_n already high.
- Reset mid-operation: register contents are lost. Bench must not expect retention.
- Write latency: data is visible in the array one edge after the commit cycle.
- Read latency: zero cycles, combinational from rs1/rs2 and array state.
- The block has no stall or handshake. Every cycle with WB_RegWrite = 1 is exactly one commit.

## Configuration
- `WB_BYPASS_EN` defined: write-first bypass. In any cycle with wb_commit = 1 and rsN == WB_rd, rdN = wb_data in the same cycle, before the edge. This removes the WB-to-ID hazard.
- `WB_BYPASS_EN` undefined: read-before-write. rdN returns the stored value in that cycle and shows the new value only after the edge. The hazard unit must then stall or forward.
- In both modes, rs = 0 returns 0 even when WB_rd = 0 and WB_RegWrite = 1.

## Test plan
- Reset check: assert rst_n low mid-run after writing x5 = 0xDEAD_BEEF. Required: rd1(rs1=5) = 0 and retire_count = 0 immediately, before any clock edge.
- Mux select: WB_MemData = 0x1111, WB_ALUResult = 0x2222, WB_rd = 3, RegWrite = 1.
  - MemToReg = 1: next cycle rd1(rs1=3) = 0x1111.
  - Repeat with MemToReg = 0: rd1 = 0x2222.
  - retire_count = 2.
- x0 protection: write 0xFFFF_FFFF_FFFF_FFFF to rd = 0 with RegWrite = 1. Required: rd1(rs1=0) = 0, wb_commit = 0, retire_count unchanged.
- Disabled write: RegWrite = 0, rd = 7, data 0xABCD. Required: x7 keeps its prior value and retire_count is unchanged.
- Same-cycle read of the write target: x9 = 0x10, then commit 0x20 to x9 with rs1 = rs2 = 9 in the same cycle.
  - With WB_BYPASS_EN: rd1 = rd2 = 0x20 in that cycle.
  - Without: both read 0x10 in that cycle and 0x20 after the edge.
- Counter wrap: run with CNT_W = 4 and issue 17 commits to x1..x17 (indices mod 32). Required: retire_count = 1 and each register holds its written value.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32 x 64-bit register file (x0 hardwired zero), two combinational read ports, commit counter.
// Optional macro WB_BYPASS_EN: a read of the register being committed returns the write-back value in the same cycle.
module wb_regfile #(
   parameter int DATA_W    = 64,
   parameter int REG_COUNT = 32,
   parameter int ADDR_W    = 5,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] WB_MemData,
   input  logic [DATA_W-1:0] WB_ALUResult,
   input  logic [ADDR_W-1:0] WB_rd,
   input  logic              WB_MemToReg,
   input  logic              WB_RegWrite,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_commit,
   output logic [CNT_W-1:0]  retire_count
);

`ifdef WB_BYPASS_EN
   localparam bit BypassEn = 1'b1;
`else
   localparam bit BypassEn = 1'b0;
`endif

   logic [DATA_W-1:0] r_regs [REG_COUNT];
   logic [CNT_W-1:0]  r_retireCount;
   logic [DATA_W-1:0] w_wbData;
   logic              w_commit;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   assign w_wbData = WB_MemToReg ? WB_MemData : WB_ALUResult;
   assign w_commit = WB_RegWrite && (WB_rd != '0);

   // Entry 0 is cleared by reset and never written, since commits to index 0 are suppressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
         r_retireCount <= '0;
      end else if (w_commit) begin
         r_regs[WB_rd] <= w_wbData;
         r_retireCount <= r_retireCount + CNT_W'(1);
      end
   end

   always_comb begin
      w_rd1 = '0;
      if (rs1 != '0) begin
         w_rd1 = r_regs[rs1];
         if (BypassEn && w_commit && (rs1 == WB_rd)) begin
            w_rd1 = w_wbData;
         end
      end
   end

   always_comb begin
      w_rd2 = '0;
      if (rs2 != '0) begin
         w_rd2 = r_regs[rs2];
         if (BypassEn && w_commit && (rs2 == WB_rd)) begin
            w_rd2 = w_wbData;
         end
      end
   end

   assign rd1          = w_rd1;
   assign rd2          = w_rd2;
   assign wb_data      = w_wbData;
   assign wb_commit    = w_commit;
   assign retire_count = r_retireCount;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile; a reference array model predicts every cycle's outputs,
// a monitor pops and compares them at the falling edge. A second instance uses a 4-bit counter to exercise wrap.
module tb_wb_regfile;

   localparam int DATA_W    = 64;
   localparam int REG_COUNT = 32;
   localparam int ADDR_W    = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] WB_MemData = '0;
   logic [DATA_W-1:0] WB_ALUResult = '0;
   logic [ADDR_W-1:0] WB_rd = '0;
   logic              WB_MemToReg = 1'b0;
   logic              WB_RegWrite = 1'b0;
   logic [ADDR_W-1:0] rs1 = '0;
   logic [ADDR_W-1:0] rs2 = '0;

   logic [DATA_W-1:0] rd1, rd2, wbData;
   logic              wbCommit;
   logic [31:0]       retireCount;
   logic [DATA_W-1:0] rd1N, rd2N, wbDataN;
   logic              wbCommitN;
   logic [3:0]        retireCountN;

   always #5 clk = ~clk;

   wb_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .ADDR_W(ADDR_W), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .WB_MemData(WB_MemData), .WB_ALUResult(WB_ALUResult),
      .WB_rd(WB_rd), .WB_MemToReg(WB_MemToReg), .WB_RegWrite(WB_RegWrite),
      .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .wb_data(wbData),
      .wb_commit(wbCommit), .retire_count(retireCount)
   );

   wb_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .ADDR_W(ADDR_W), .CNT_W(4)) dutNarrow (
      .clk(clk), .rst_n(rst_n), .WB_MemData(WB_MemData), .WB_ALUResult(WB_ALUResult),
      .WB_rd(WB_rd), .WB_MemToReg(WB_MemToReg), .WB_RegWrite(WB_RegWrite),
      .rs1(rs1), .rs2(rs2), .rd1(rd1N), .rd2(rd2N), .wb_data(wbDataN),
      .wb_commit(wbCommitN), .retire_count(retireCountN)
   );

   typedef struct {
      logic [63:0] rd1;
      logic [63:0] rd2;
      logic [63:0] wbData;
      logic        commit;
      logic [31:0] count;
      logic [3:0]  countNarrow;
   } expect_t;

   expect_t expQ[$];
   string   nameQ[$];
   int      total = 0;
   int      bad = 0;

   // Reference model: architectural contents plus the commit decided in the current cycle, applied at the next edge.
   logic [63:0] modelRegs [REG_COUNT];
   int unsigned modelCount = 0;
   bit          pendCommit = 1'b0;
   logic [4:0]  pendRd = '0;
   logic [63:0] pendData = '0;
   bit          pendRstN = 1'b0;

   function automatic logic [63:0] modelRead(input logic [4:0] rs, input bit commit,
                                             input logic [4:0] rd, input logic [63:0] sel);
      if (rs == 5'd0) return 64'd0;
`ifdef WB_BYPASS_EN
      if (commit && rs == rd) return sel;
`endif
      return modelRegs[rs];
   endfunction

   task automatic applyStimulus(input bit rstN, input logic [63:0] mem, input logic [63:0] alu,
                                input logic [4:0] rd, input bit m2r, input bit we,
                                input logic [4:0] a, input logic [4:0] b, input string name);
      expect_t     e;
      logic [63:0] sel;
      bit          commit;
      @(posedge clk);
      #1;
      if (pendRstN && pendCommit) begin
         modelRegs[pendRd] = pendData;
         modelCount++;
      end
      rst_n        = rstN;
      WB_MemData   = mem;
      WB_ALUResult = alu;
      WB_rd        = rd;
      WB_MemToReg  = m2r;
      WB_RegWrite  = we;
      rs1          = a;
      rs2          = b;
      if (!rstN) begin
         for (int i = 0; i < REG_COUNT; i++) modelRegs[i] = 64'd0;
         modelCount = 0;
      end
      sel           = m2r ? mem : alu;
      commit        = we && (rd != 5'd0);
      e.rd1         = modelRead(a, commit, rd, sel);
      e.rd2         = modelRead(b, commit, rd, sel);
      e.wbData      = sel;
      e.commit      = commit;
      e.count       = modelCount;
      e.countNarrow = 4'(modelCount % 16);
      expQ.push_back(e);
      nameQ.push_back(name);
      pendCommit = commit;
      pendRd     = rd;
      pendData   = sel;
      pendRstN   = rstN;
   endtask

   task automatic checkField(input string name, input string field,
                             input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input expect_t e);
      checkField(name, "rd1", rd1, e.rd1);
      checkField(name, "rd2", rd2, e.rd2);
      checkField(name, "wb_data", wbData, e.wbData);
      checkField(name, "wb_commit", 64'(wbCommit), 64'(e.commit));
      checkField(name, "retire_count", 64'(retireCount), 64'(e.count));
      checkField(name, "narrow.rd1", rd1N, e.rd1);
      checkField(name, "narrow.rd2", rd2N, e.rd2);
      checkField(name, "narrow.wb_data", wbDataN, e.wbData);
      checkField(name, "narrow.wb_commit", 64'(wbCommitN), 64'(e.commit));
      checkField(name, "narrow.retire_count", 64'(retireCountN), 64'(e.countNarrow));
   endtask

   initial begin : monitor
      expect_t e;
      string   n;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            checkOutput(n, e);
         end
      end
   end

   initial begin : driver
      logic [4:0] a, b, rd;
      bit         rstN, we;
      for (int i = 0; i < REG_COUNT; i++) modelRegs[i] = 64'd0;

      applyStimulus(1'b0, 64'h5, 64'h6, 5'd4, 1'b0, 1'b1, 5'd4, 5'd31, "resetHold0");
      applyStimulus(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd17, "resetHold1");

      applyStimulus(1'b1, 64'h1111, 64'h2222, 5'd3, 1'b1, 1'b1, 5'd3, 5'd0, "muxMem");
      applyStimulus(1'b1, 64'h1111, 64'h2222, 5'd3, 1'b0, 1'b1, 5'd3, 5'd3, "muxAlu");
      applyStimulus(1'b1, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, "muxRead");

      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, "x0Write");
      applyStimulus(1'b1, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, "x0Read");

      applyStimulus(1'b1, 64'h0, 64'h77, 5'd7, 1'b0, 1'b1, 5'd7, 5'd7, "x7Init");
      applyStimulus(1'b1, 64'hABCD, 64'hABCD, 5'd7, 1'b1, 1'b0, 5'd7, 5'd7, "x7Disabled");
      applyStimulus(1'b1, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, "x7Read");

      applyStimulus(1'b1, 64'h0, 64'h10, 5'd9, 1'b0, 1'b1, 5'd0, 5'd0, "x9Init");
      applyStimulus(1'b1, 64'h0, 64'h20, 5'd9, 1'b0, 1'b1, 5'd9, 5'd9, "x9Same");
      applyStimulus(1'b1, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd9, "x9After");

      applyStimulus(1'b1, 64'h0, 64'hDEAD_BEEF, 5'd5, 1'b0, 1'b1, 5'd0, 5'd0, "x5Write");
      applyStimulus(1'b1, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, "x5Read");
      applyStimulus(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd5, "midReset");
      applyStimulus(1'b1, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd5, 5'd9, "resetRelease");

      applyStimulus(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, "wrapReset");
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(1'b1, {$urandom(), $urandom()}, 64'(i * 16'h101), 5'(i % 32), 1'b0, 1'b1,
                       5'(i % 32), 5'((i + 1) % 32), "wrapCommit");
      end
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(1'b1, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'(i), 5'($urandom_range(0, 31)), "wrapRead");
      end

      for (int i = 0; i < 300; i++) begin
         rstN = ($urandom_range(0, 39) != 0);
         we   = 1'($urandom_range(0, 1));
         rd   = 5'($urandom_range(0, 31));
         a    = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         b    = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         if (!rstN) begin
            b  = a;
            rd = a ^ 5'd1;
         end
         applyStimulus(rstN, {$urandom(), $urandom()}, {$urandom(), $urandom()}, rd,
                       1'($urandom_range(0, 1)), we, a, b, "random");
      end

      repeat (3) @(negedge clk);
      #1;
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
